// File: rtl/approx_serial_subtractor.sv
// rtl/approx_serial_subtractor.sv - bit-serial approximate subtractor, LSB first (optional APPROX_ERR_EN exact-compare monitor)
module approx_serial_subtractor #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef APPROX_ERR_EN
    ,
    output logic             err_flag,
    output logic [15:0]      err_cnt
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    // Bit i set => position i uses the approximate cell
    localparam logic [WIDTH-1:0] APPROX_MASK = {WIDTH{1'b1}} >> (WIDTH - APPROX_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             x, y, s, carry_nx;
    logic [WIDTH-1:0] diff_nx;
    logic             accept, last_bit, out_hs;

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == SHIFT) && (idx == IDX_LAST);
    assign out_hs   = (state == DONE) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SHIFT;
            SHIFT:   if (idx == IDX_LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single adder cell: approximate (OR / AND, carry-in ignored) or exact full adder
    always_comb begin
        x = a_q[idx];
        y = nb_q[idx];
        if (APPROX_MASK[idx]) begin
            s        = x | y;
            carry_nx = x & y;
        end else begin
            s        = x ^ y ^ carry;
            carry_nx = (x & y) | (x & carry) | (y & carry);
        end
    end

    // Result with the current bit written in place
    always_comb begin
        diff_nx      = diff;
        diff_nx[idx] = s;
    end

    // Operand capture and serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            nb_q   <= '0;
            idx    <= '0;
            carry  <= 1'b1;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            nb_q  <= ~b;
            idx   <= '0;
            carry <= 1'b1;
        end else if (state == SHIFT) begin
            diff  <= diff_nx;
            carry <= carry_nx;
            if (last_bit) begin
                borrow <= ~carry_nx;
                idx    <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef APPROX_ERR_EN
    logic [WIDTH:0] exact_q;

    // Exact reference captured at acceptance; flag set as the result completes, counted on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_q  <= '0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (accept)
                exact_q <= {1'b0, a} - {1'b0, b};
            if (last_bit)
                err_flag <= ({~carry_nx, diff_nx} != exact_q);
            if (out_hs && err_flag && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_approx_serial_subtractor.sv
// tb/tb_approx_serial_subtractor.sv - directed self-checking bench for approx_serial_subtractor
module tb_approx_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready, out_valid, borrow;
    logic [7:0] diff;
    logic       in_ready0, out_valid0, borrow0;
    logic [7:0] diff0;
`ifdef APPROX_ERR_EN
    logic        err_flag, err_flag0;
    logic [15:0] err_cnt, err_cnt0;
    int          exp_cnt = 0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    approx_serial_subtractor #(.WIDTH(8), .APPROX_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
`ifdef APPROX_ERR_EN
        , .err_flag(err_flag), .err_cnt(err_cnt)
`endif
    );

    approx_serial_subtractor #(.WIDTH(8), .APPROX_BITS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .diff(diff0), .borrow(borrow0)
`ifdef APPROX_ERR_EN
        , .err_flag(err_flag0), .err_cnt(err_cnt0)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge, scramble them afterwards, then wait for out_valid
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, output int lat);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~av;
        b = av ^ bv;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h want 00", diff); end
        n_cmp++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b want 0", borrow); end
`ifdef APPROX_ERR_EN
        n_cmp++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag: got %b want 0", err_flag); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        exp_cnt = 0;
`endif
        rst_n = 1'b1;
        tick();
    endtask

    // Directed vectors: approximate result, exact reference instance, and error monitor
    task automatic test_vectors;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] ed [3];
        logic       eb [3];
        logic [7:0] xd [3];
        logic       xb [3];
        logic       ef [3];
        int lat;
        va = '{8'h20, 8'h07, 8'h05};
        vb = '{8'h08, 8'h00, 8'h07};
        ed = '{8'h17, 8'h07, 8'hFD};
        eb = '{1'b0, 1'b0, 1'b1};
        xd = '{8'h18, 8'h07, 8'hFE};
        xb = '{1'b0, 1'b0, 1'b1};
        ef = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], lat);
            n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want 8", i, lat); end
            n_cmp++; if (diff !== ed[i]) begin n_fail++; $display("FAIL vec%0d_diff: got %h want %h", i, diff, ed[i]); end
            n_cmp++; if (borrow !== eb[i]) begin n_fail++; $display("FAIL vec%0d_borrow: got %b want %b", i, borrow, eb[i]); end
            n_cmp++; if (diff0 !== xd[i]) begin n_fail++; $display("FAIL vec%0d_exact_diff: got %h want %h", i, diff0, xd[i]); end
            n_cmp++; if (borrow0 !== xb[i]) begin n_fail++; $display("FAIL vec%0d_exact_borrow: got %b want %b", i, borrow0, xb[i]); end
`ifdef APPROX_ERR_EN
            n_cmp++; if (err_flag !== ef[i]) begin n_fail++; $display("FAIL vec%0d_err_flag: got %b want %b", i, err_flag, ef[i]); end
            n_cmp++; if (err_flag0 !== 1'b0) begin n_fail++; $display("FAIL vec%0d_exact_err_flag: got %b want 0", i, err_flag0); end
            if (ef[i]) exp_cnt++;
`endif
            handshake();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_out_valid_drop: got %b want 0", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_idle: got %b want 1", i, in_ready); end
`ifdef APPROX_ERR_EN
            n_cmp++; if (err_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL vec%0d_err_cnt: got %0d want %0d", i, err_cnt, exp_cnt); end
`endif
        end
    endtask

    task automatic test_backpressure;
        int lat;
        run_op(8'h20, 8'h08, lat);
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'(i * 37 + 1);
            b = 8'(i * 91 + 5);
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid%0d: got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
            n_cmp++; if ({borrow, diff} !== 9'h017) begin n_fail++; $display("FAIL bp_result%0d: got %h want 017", i, {borrow, diff}); end
        end
`ifdef APPROX_ERR_EN
        exp_cnt++;
`endif
        in_valid = 1'b0;
        handshake();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept: got %b want 1", in_ready); end
`ifdef APPROX_ERR_EN
        n_cmp++; if (err_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_err_cnt: got %0d want %0d", err_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_reset_mid_op;
        int lat;
        a = 8'h07;
        b = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (diff !== 8'h00) begin n_fail++; $display("FAIL midrst_diff: got %h want 00", diff); end
`ifdef APPROX_ERR_EN
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
        exp_cnt = 0;
`endif
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result: got %b want 0", out_valid); end
        run_op(8'h07, 8'h00, lat);
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL midrst_next_latency: got %0d want 8", lat); end
        n_cmp++; if ({borrow, diff} !== 9'h007) begin n_fail++; $display("FAIL midrst_next_result: got %h want 007", {borrow, diff}); end
        handshake();
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [8:0] er [3];
        int n;
        va = '{8'h20, 8'h07, 8'h05};
        vb = '{8'h08, 8'h00, 8'h07};
        er = '{9'h017, 9'h007, 9'h1FD};
        a = va[0];
        b = vb[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n = 0;
            if (i > 0) begin
                tick();
                n = 1;
            end
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            n_cmp++; if (n !== ((i == 0) ? 8 : 10)) begin n_fail++; $display("FAIL b2b%0d_spacing: got %0d want %0d", i, n, (i == 0) ? 8 : 10); end
            n_cmp++; if ({borrow, diff} !== er[i]) begin n_fail++; $display("FAIL b2b%0d_result: got %h want %h", i, {borrow, diff}, er[i]); end
            if (i < 2) begin
                a = va[i+1];
                b = vb[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final_drop: got %b want 0", out_valid); end
`ifdef APPROX_ERR_EN
        n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d want 2", err_cnt); end
`endif
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
